// File: rtl/pcpi_pkg.sv
// -----------------------------------------------------------------------------
// pcpi_pkg
// Shared types and constants for the PCPI issuer.
//   state_t    : issuer FSM states (IDLE, ISSUE, RESP)
//   pcpi_op_t  : instruction word plus both operands, registered as one unit
//   OPC_OP, FUNCT7_MULDIV : opcode fields of the RV32M multiply/divide group
//   is_muldiv  : helper that recognises an RV32M instruction word
// -----------------------------------------------------------------------------
package pcpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } pcpi_op_t;

    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[6:0] == OPC_OP) && (insn[31:25] == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// -----------------------------------------------------------------------------
// pcpi_timeout_ctr
// Down-counter that decides when an offered PCPI instruction has gone
// unclaimed for too long. Only built when PCPI_TIMEOUT_EN is defined.
//   clk, resetn : clock, synchronous active-low reset (counter -> TIMEOUT_CYCLES)
//   i_load      : reload to TIMEOUT_CYCLES (new request, or coprocessor busy)
//   i_dec       : count one idle cycle
//   o_expired   : counter has reached zero
// Load wins over decrement; the counter saturates at zero.
// -----------------------------------------------------------------------------
`ifdef PCPI_TIMEOUT_EN
module pcpi_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= LOAD_VAL;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule
`endif

// File: rtl/pcpi_issuer.sv
// -----------------------------------------------------------------------------
// pcpi_issuer
// Initiator side of the PCPI coprocessor interface. Takes one instruction and
// two operands from the core, offers them to the coprocessors, waits for
// pcpi_ready and hands the result (or an illegal-instruction flag on timeout)
// back to the core.
//
// Configuration macro: PCPI_TIMEOUT_EN
//   defined   : unclaimed instructions time out after TIMEOUT_CYCLES+1 cycles
//               of pcpi_valid with neither pcpi_wait nor pcpi_ready; the
//               response then carries rsp_illegal=1, rsp_wr=0, rsp_rd=0.
//   undefined : no counter; ISSUE waits for pcpi_ready forever and
//               rsp_illegal is tied to 0.
//
// Ports
//   clk, resetn       : clock, synchronous active-low reset
//   req_valid/ready   : request handshake from the core (insn, rs1, rs2)
//   pcpi_valid/insn/rs1/rs2 : instruction offered to the coprocessors
//   pcpi_wr/rd/wait/ready   : coprocessor reply
//   rsp_valid/ready   : response handshake to the core (wr, rd, illegal)
//   o_dbg_state       : current FSM state (state_t encoding)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE, rsp_valid only in RESP; both
// depend on state alone, so neither side sees a combinational path through
// this block. Response fields stay constant while rsp_valid is high.
// Throughput: one instruction per (coprocessor latency + 3) cycles; there is
// no bypass from RESP straight into a new request.
// -----------------------------------------------------------------------------
module pcpi_issuer
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        resetn,
    // request from core
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    // PCPI
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    // response to core
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_illegal,
    // debug
    output logic [1:0]  o_dbg_state
);

    // Reject configurations where the counter cannot hold the load value.
    localparam bit CFG_OK = (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 255) &&
                            (CNT_W >= 1) && (CNT_W <= 31) &&
                            ((1 << CNT_W) > TIMEOUT_CYCLES);
    if (!CFG_OK) begin : g_bad_cfg
        $error("pcpi_issuer: TIMEOUT_CYCLES must be 1..255 and fit in CNT_W bits");
    end

    state_t   r_state;
    state_t   w_state_nxt;
    pcpi_op_t r_op;
    logic     r_rsp_wr;
    logic [31:0] r_rsp_rd;

    logic w_accept;
    logic w_done;
    logic w_timeout;

    assign w_accept = (r_state == IDLE)  && req_valid;
    // pcpi_ready outside ISSUE is ignored by construction.
    assign w_done   = (r_state == ISSUE) && pcpi_ready;

`ifdef PCPI_TIMEOUT_EN
    logic w_expired;
    logic w_ctr_load;
    logic w_ctr_dec;
    logic r_rsp_illegal;

    // pcpi_ready outranks both wait and expiry in the same cycle.
    assign w_ctr_load = w_accept || ((r_state == ISSUE) && !pcpi_ready && pcpi_wait);
    assign w_ctr_dec  = (r_state == ISSUE) && !pcpi_ready && !pcpi_wait;
    assign w_timeout  = w_ctr_dec && w_expired;

    pcpi_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_ctr (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_ctr_load),
        .i_dec     (w_ctr_dec),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rsp_illegal <= 1'b0;
        end else if (w_done) begin
            r_rsp_illegal <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_illegal <= 1'b1;
        end
    end

    assign rsp_illegal = r_rsp_illegal;
`else
    // Busy indication only matters to the timeout logic.
    logic w_unused_wait;
    assign w_unused_wait = pcpi_wait;
    assign w_timeout     = 1'b0;
    assign rsp_illegal   = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid)            w_state_nxt = ISSUE;
            ISSUE:   if (w_done || w_timeout)  w_state_nxt = RESP;
            RESP:    if (rsp_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------ data registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op <= '0;
        end else if (w_accept) begin
            r_op <= '{insn: req_insn, rs1: req_rs1, rs2: req_rs2};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rsp_wr <= 1'b0;
            r_rsp_rd <= '0;
        end else if (w_done) begin
            r_rsp_wr <= pcpi_wr;
            r_rsp_rd <= pcpi_rd;
        end else if (w_timeout) begin
            r_rsp_wr <= 1'b0;
            r_rsp_rd <= '0;
        end
    end

    // -------------------------------------------------------------- outputs
    assign req_ready   = (r_state == IDLE);
    assign pcpi_valid  = (r_state == ISSUE);
    assign rsp_valid   = (r_state == RESP);
    assign pcpi_insn   = r_op.insn;
    assign pcpi_rs1    = r_op.rs1;
    assign pcpi_rs2    = r_op.rs2;
    assign rsp_wr      = r_rsp_wr;
    assign rsp_rd      = r_rsp_rd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pcpi_issuer.sv
// -----------------------------------------------------------------------------
// tb_pcpi_issuer
// Directed bench for pcpi_issuer with TIMEOUT_CYCLES=16. The bench plays the
// core and a small multiplier coprocessor (MUL / MULHU). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, so every
// value observed reflects the state reached on the preceding edge.
// -----------------------------------------------------------------------------
module tb_pcpi_issuer;
    import pcpi_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_illegal;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] INSN_MUL   = {FUNCT7_MULDIV, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP};
    localparam logic [31:0] INSN_MULHU = {FUNCT7_MULDIV, 5'd2, 5'd1, 3'b011, 5'd3, OPC_OP};
    localparam logic [31:0] INSN_CUSTOM = 32'h0000_018B;

    always #5 clk = ~clk;

    pcpi_issuer #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_insn    (req_insn),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_rs1    (pcpi_rs1),
        .pcpi_rs2    (pcpi_rs2),
        .pcpi_wr     (pcpi_wr),
        .pcpi_rd     (pcpi_rd),
        .pcpi_wait   (pcpi_wait),
        .pcpi_ready  (pcpi_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_wr      (rsp_wr),
        .rsp_rd      (rsp_rd),
        .rsp_illegal (rsp_illegal),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request in IDLE; returns one edge later (DUT in ISSUE).
    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        step();
        req_valid = 1'b0;
    endtask

    // Coprocessor: busy for wait_cycles, then a one-cycle pcpi_ready pulse.
    task automatic copro(input int wait_cycles, input logic wr, input logic [31:0] rd);
        for (int i = 0; i < wait_cycles; i++) begin
            pcpi_wait = 1'b1;
            step();
        end
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        step();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Multiplier coprocessor behaviour (MUL, MULHU only).
    function automatic logic [31:0] mul_model(input logic [31:0] insn,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (insn[14:12])
            3'b000:  return p[31:0];
            3'b011:  return p[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0; rsp_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if (req_ready !== 1'b1 || pcpi_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: req_ready=%b pcpi_valid=%b rsp_valid=%b exp 1 0 0",
                     req_ready, pcpi_valid, rsp_valid);
        end
        n_checks++;
        if (pcpi_insn !== 32'd0 || pcpi_rs1 !== 32'd0 || pcpi_rs2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_op: insn=%h rs1=%h rs2=%h exp 0", pcpi_insn, pcpi_rs1, pcpi_rs2);
        end
        n_checks++;
        if (rsp_wr !== 1'b0 || rsp_rd !== 32'd0 || rsp_illegal !== 1'b0 || o_dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: wr=%b rd=%h illegal=%b state=%0d exp 0 0 0 0",
                     rsp_wr, rsp_rd, rsp_illegal, o_dbg_state);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_mul();
        issue(INSN_MUL, 32'd7, 32'd6);
        n_checks++;
        if (pcpi_valid !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_issue: pcpi_valid=%b req_ready=%b exp 1 0", pcpi_valid, req_ready);
        end
        n_checks++;
        if (pcpi_insn !== INSN_MUL || pcpi_rs1 !== 32'd7 || pcpi_rs2 !== 32'd6) begin
            n_fail++;
            $display("FAIL mul_operands: insn=%h rs1=%0d rs2=%0d exp %h 7 6",
                     pcpi_insn, pcpi_rs1, pcpi_rs2, INSN_MUL);
        end
        copro(2, 1'b1, mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2));
        n_checks++;
        if (pcpi_valid !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_resp_hs: pcpi_valid=%b rsp_valid=%b exp 0 1", pcpi_valid, rsp_valid);
        end
        n_checks++;
        if (rsp_rd !== 32'd42 || rsp_wr !== 1'b1 || rsp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result: rd=%0d wr=%b illegal=%b exp 42 1 0", rsp_rd, rsp_wr, rsp_illegal);
        end
        consume();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_consume: rsp_valid=%b req_ready=%b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_mulhu_long_wait();
        int bad;
        bad = 0;
        issue(INSN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 20; i++) begin
            pcpi_wait = 1'b1;
            step();
            if (pcpi_valid !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mulhu_wait_hold: %0d cycles left ISSUE early, exp 0", bad);
        end
        copro(0, 1'b1, mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2));
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rd !== 32'hFFFF_FFFE || rsp_illegal !== 1'b0 || rsp_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL mulhu_result: valid=%b rd=%h illegal=%b wr=%b exp 1 fffffffe 0 1",
                     rsp_valid, rsp_rd, rsp_illegal, rsp_wr);
        end
        consume();
    endtask

`ifdef PCPI_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        cnt = 0;
        issue(INSN_CUSTOM, 32'd1, 32'd2);
        for (int i = 0; i < 40 && pcpi_valid === 1'b1; i++) begin
            cnt++;
            step();
        end
        n_checks++;
        if (cnt !== 17) begin
            n_fail++;
            $display("FAIL timeout_len: pcpi_valid cycles=%0d exp 17", cnt);
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_rd !== 32'd0 || rsp_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid=%b illegal=%b rd=%h wr=%b exp 1 1 0 0",
                     rsp_valid, rsp_illegal, rsp_rd, rsp_wr);
        end
        consume();
    endtask
`else
    task automatic test_timeout();
        int cnt;
        cnt = 0;
        issue(INSN_CUSTOM, 32'd1, 32'd2);
        for (int i = 0; i < 40; i++) begin
            if (pcpi_valid === 1'b1 && rsp_valid === 1'b0) cnt++;
            step();
        end
        n_checks++;
        if (cnt !== 40) begin
            n_fail++;
            $display("FAIL no_timeout_hold: issue cycles=%0d exp 40", cnt);
        end
        copro(0, 1'b1, 32'h0000_CAFE);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rd !== 32'h0000_CAFE || rsp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_rsp: valid=%b rd=%h illegal=%b exp 1 cafe 0",
                     rsp_valid, rsp_rd, rsp_illegal);
        end
        consume();
    endtask
`endif

    // pcpi_ready arrives in the cycle the counter sits at zero.
    task automatic test_ready_at_expiry();
        issue(INSN_CUSTOM, 32'd3, 32'd4);
        repeat (16) step();
        n_checks++;
        if (pcpi_valid !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_still_issue: pcpi_valid=%b rsp_valid=%b exp 1 0", pcpi_valid, rsp_valid);
        end
        copro(0, 1'b1, 32'h1234_5678);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b0 || rsp_rd !== 32'h1234_5678 || rsp_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL expiry_priority: valid=%b illegal=%b rd=%h wr=%b exp 1 0 12345678 1",
                     rsp_valid, rsp_illegal, rsp_rd, rsp_wr);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        issue(INSN_MUL, 32'd3, 32'd5);
        exp_q.push_back(32'd15);
        copro(0, 1'b1, mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2));
        // Next request waits on the port while the response is stalled.
        req_valid = 1'b1; req_insn = INSN_MUL; req_rs1 = 32'd4; req_rs2 = 32'd5;
        exp_q.push_back(32'd20);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rd !== 32'd15 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: rsp_valid=%b rd=%0d req_ready=%b exp 1 15 0",
                         i, rsp_valid, rsp_rd, req_ready);
            end
        end
        n_checks++;
        if (rsp_rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_first: rd=%0d exp %0d", rsp_rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
        consume();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || pcpi_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_bypass: req_ready=%b rsp_valid=%b pcpi_valid=%b exp 1 0 0",
                     req_ready, rsp_valid, pcpi_valid);
        end
        step();
        req_valid = 1'b0;
        n_checks++;
        if (pcpi_valid !== 1'b1 || pcpi_rs1 !== 32'd4 || pcpi_rs2 !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_second_issue: pcpi_valid=%b rs1=%0d rs2=%0d exp 1 4 5",
                     pcpi_valid, pcpi_rs1, pcpi_rs2);
        end
        copro(1, 1'b1, mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2));
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b rd=%0d exp 1 %0d", rsp_valid, rsp_rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
        consume();
        issue(INSN_MUL, 32'd9, 32'd9);
        copro(0, 1'b1, mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2));
        n_checks++;
        if (rsp_rd !== 32'd81) begin
            n_fail++;
            $display("FAIL b2b_third: rd=%0d exp 81", rsp_rd);
        end
        consume();
    endtask

    task automatic test_reset_mid_issue();
        int bad;
        bad = 0;
        issue(INSN_MUL, 32'd11, 32'd13);
        step();
        step();
        resetn = 1'b0;
        step();
        n_checks++;
        if (pcpi_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_hs: pcpi_valid=%b req_ready=%b rsp_valid=%b exp 0 1 0",
                     pcpi_valid, req_ready, rsp_valid);
        end
        n_checks++;
        if (pcpi_insn !== 32'd0 || rsp_rd !== 32'd0 || o_dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_regs: insn=%h rd=%h state=%0d exp 0 0 0", pcpi_insn, rsp_rd, o_dbg_state);
        end
        resetn = 1'b1;
        // A stale coprocessor reply after reset must be ignored.
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd143;
        step();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0 || pcpi_valid !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0 || rsp_rd !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_no_response: bad cycles=%0d rd=%h exp 0 0", bad, rsp_rd);
        end
        issue(INSN_MUL, 32'd2, 32'd8);
        copro(0, 1'b1, mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2));
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rd !== 32'd16) begin
            n_fail++;
            $display("FAIL rst_recover: valid=%b rd=%0d exp 1 16", rsp_valid, rsp_rd);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhu_long_wait();
        test_timeout();
        test_ready_at_expiry();
        test_back_to_back();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
